// File: rtl/axi_ddr_guard_pkg.sv
// Shared types and encodings for the AXI DDR guard: FSM states, AXI response
// codes and the bit positions of the sticky error flags.
package axi_ddr_guard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int ERR_SLVERR  = 0;
   localparam int ERR_DECERR  = 1;
   localparam int ERR_TIMEOUT = 2;

   // Maps a response code onto {decerr, slverr}.
   function automatic logic [1:0] resp_err(input logic [1:0] resp);
      logic [1:0] bits;
      bits = 2'b00;
      case (resp)
         RESP_OKAY, RESP_EXOKAY: bits = 2'b00;
         RESP_SLVERR:            bits = 2'b01;
         RESP_DECERR:            bits = 2'b10;
         default:                bits = 2'b00;
      endcase
      return bits;
   endfunction

endpackage

// File: rtl/axi_ddr_guard_dir.sv
// One direction of the guard: address gate with sticky pending flag,
// outstanding-burst counter and no-progress timer.
module axi_ddr_guard_dir
   import axi_ddr_guard_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic allow,
   input  logic clear_timer,
   input  logic s_valid,
   output logic s_ready,
   output logic m_valid,
   input  logic m_ready,
   input  logic rsp_done,
   input  logic activity,
   output logic pending,
   output logic timeout,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] count
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(TIMEOUT_CYCLES);

   logic [TMR_W-1:0] timer;
   logic             gate_open;
   logic             a_hs;

   // Handshake rule: a transfer happens on a cycle where valid and ready are both
   // high. Once m_valid rises it is held by the pending flag until m_ready, even
   // if the FSM leaves RUN, so the slave never sees a withdrawn address.
   assign gate_open = allow && (count < CNT_MAX) && !pending;
   assign m_valid   = pending || (gate_open && s_valid);
   assign a_hs      = m_valid && m_ready;
   assign s_ready   = a_hs;
   assign timeout   = (count != '0) && (timer == TMR_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         count   <= '0;
         timer   <= '0;
      end else begin
         pending <= m_valid && !m_ready;
         if (a_hs && !rsp_done)
            count <= count + 1'b1;
         else if (rsp_done && !a_hs && count != '0)
            count <= count - 1'b1;
         // Timer saturates one past the trip point so the timeout is a single pulse.
         if (clear_timer || count == '0 || a_hs || activity)
            timer <= '0;
         else if (timer != TMR_SAT)
            timer <= timer + 1'b1;
      end
   end

   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(rsp_done && !a_hs && count == '0));

endmodule

// File: rtl/axi_ddr_guard.sv
// AXI4 guard in front of a DDR controller: limits outstanding bursts per
// direction, detects stalled responses and records error responses.
module axi_ddr_guard
   import axi_ddr_guard_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int AXI_DATA_WIDTH  = 32,
   parameter int AXI_ID_WIDTH    = 4,
   parameter int AXI_USER_WIDTH  = 1,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic [AXI_ID_WIDTH-1:0]     s_awid,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
   input  logic [7:0]                  s_awlen,
   input  logic [2:0]                  s_awsize,
   input  logic [1:0]                  s_awburst,
   input  logic                        s_awlock,
   input  logic [3:0]                  s_awcache,
   input  logic [2:0]                  s_awprot,
   input  logic [3:0]                  s_awqos,
   input  logic [3:0]                  s_awregion,
   input  logic [AXI_USER_WIDTH-1:0]   s_awuser,
   input  logic                        s_awvalid,
   output logic                        s_awready,
   input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                        s_wlast,
   input  logic [AXI_USER_WIDTH-1:0]   s_wuser,
   input  logic                        s_wvalid,
   output logic                        s_wready,
   output logic [AXI_ID_WIDTH-1:0]     s_bid,
   output logic [1:0]                  s_bresp,
   output logic [AXI_USER_WIDTH-1:0]   s_buser,
   output logic                        s_bvalid,
   input  logic                        s_bready,
   input  logic [AXI_ID_WIDTH-1:0]     s_arid,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
   input  logic [7:0]                  s_arlen,
   input  logic [2:0]                  s_arsize,
   input  logic [1:0]                  s_arburst,
   input  logic                        s_arlock,
   input  logic [3:0]                  s_arcache,
   input  logic [2:0]                  s_arprot,
   input  logic [3:0]                  s_arqos,
   input  logic [3:0]                  s_arregion,
   input  logic [AXI_USER_WIDTH-1:0]   s_aruser,
   input  logic                        s_arvalid,
   output logic                        s_arready,
   output logic [AXI_ID_WIDTH-1:0]     s_rid,
   output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]                  s_rresp,
   output logic                        s_rlast,
   output logic [AXI_USER_WIDTH-1:0]   s_ruser,
   output logic                        s_rvalid,
   input  logic                        s_rready,
   output logic [AXI_ID_WIDTH-1:0]     m_awid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_awaddr,
   output logic [7:0]                  m_awlen,
   output logic [2:0]                  m_awsize,
   output logic [1:0]                  m_awburst,
   output logic                        m_awlock,
   output logic [3:0]                  m_awcache,
   output logic [2:0]                  m_awprot,
   output logic [3:0]                  m_awqos,
   output logic [3:0]                  m_awregion,
   output logic [AXI_USER_WIDTH-1:0]   m_awuser,
   output logic                        m_awvalid,
   input  logic                        m_awready,
   output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
   output logic                        m_wlast,
   output logic [AXI_USER_WIDTH-1:0]   m_wuser,
   output logic                        m_wvalid,
   input  logic                        m_wready,
   input  logic [AXI_ID_WIDTH-1:0]     m_bid,
   input  logic [1:0]                  m_bresp,
   input  logic [AXI_USER_WIDTH-1:0]   m_buser,
   input  logic                        m_bvalid,
   output logic                        m_bready,
   output logic [AXI_ID_WIDTH-1:0]     m_arid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_araddr,
   output logic [7:0]                  m_arlen,
   output logic [2:0]                  m_arsize,
   output logic [1:0]                  m_arburst,
   output logic                        m_arlock,
   output logic [3:0]                  m_arcache,
   output logic [2:0]                  m_arprot,
   output logic [3:0]                  m_arqos,
   output logic [3:0]                  m_arregion,
   output logic [AXI_USER_WIDTH-1:0]   m_aruser,
   output logic                        m_arvalid,
   input  logic                        m_arready,
   input  logic [AXI_ID_WIDTH-1:0]     m_rid,
   input  logic [AXI_DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]                  m_rresp,
   input  logic                        m_rlast,
   input  logic [AXI_USER_WIDTH-1:0]   m_ruser,
   input  logic                        m_rvalid,
   output logic                        m_rready,
   input  logic enable_i,
   input  logic clear_i,
   output logic [1:0] state_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_outstanding_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding_o,
   output logic [2:0] err_o,
   output logic [AXI_ID_WIDTH-1:0] err_id_o
);

   state_t     state, state_next;
   logic       run, leave_halt;
   logic       wr_to, rd_to, any_to, wr_pend, rd_pend, drained;
   logic       b_hs, r_hs;
   logic [1:0] b_err, r_err, rsp_err;
   logic [2:0] err_next;

   assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock} =
          {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock};
   assign {m_awcache, m_awprot, m_awqos, m_awregion, m_awuser} =
          {s_awcache, s_awprot, s_awqos, s_awregion, s_awuser};
   assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock} =
          {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock};
   assign {m_arcache, m_arprot, m_arqos, m_arregion, m_aruser} =
          {s_arcache, s_arprot, s_arqos, s_arregion, s_aruser};
   assign {m_wdata, m_wstrb, m_wlast, m_wuser, m_wvalid} = {s_wdata, s_wstrb, s_wlast, s_wuser, s_wvalid};
   assign s_wready = m_wready;
   assign {s_bid, s_bresp, s_buser, s_bvalid} = {m_bid, m_bresp, m_buser, m_bvalid};
   assign m_bready = s_bready;
   assign {s_rid, s_rdata, s_rresp, s_rlast, s_ruser, s_rvalid} = {m_rid, m_rdata, m_rresp, m_rlast, m_ruser, m_rvalid};
   assign m_rready = s_rready;

   assign b_hs = m_bvalid && s_bready;
   assign r_hs = m_rvalid && s_rready;

   axi_ddr_guard_dir #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr (
      .clk(clk), .rst_n(rst_n), .allow(run), .clear_timer(leave_halt),
      .s_valid(s_awvalid), .s_ready(s_awready), .m_valid(m_awvalid), .m_ready(m_awready),
      .rsp_done(b_hs), .activity((s_wvalid && m_wready) || b_hs),
      .pending(wr_pend), .timeout(wr_to), .count(wr_outstanding_o)
   );

   axi_ddr_guard_dir #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd (
      .clk(clk), .rst_n(rst_n), .allow(run), .clear_timer(leave_halt),
      .s_valid(s_arvalid), .s_ready(s_arready), .m_valid(m_arvalid), .m_ready(m_arready),
      .rsp_done(r_hs && m_rlast), .activity(r_hs),
      .pending(rd_pend), .timeout(rd_to), .count(rd_outstanding_o)
   );

   assign any_to  = wr_to || rd_to;
   assign drained = (wr_outstanding_o == '0) && (rd_outstanding_o == '0) && !wr_pend && !rd_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Re-enabling while draining goes straight back to RUN.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (enable_i) state_next = ST_RUN;
         ST_RUN:   if (any_to) state_next = ST_HALT;
                   else if (!enable_i) state_next = ST_DRAIN;
         ST_DRAIN: if (any_to) state_next = ST_HALT;
                   else if (enable_i) state_next = ST_RUN;
                   else if (drained) state_next = ST_IDLE;
         ST_HALT:  if (clear_i) state_next = enable_i ? ST_RUN : ST_DRAIN;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      run        = 1'b0;
      leave_halt = 1'b0;
      case (state)
         ST_RUN:  run = 1'b1;
         ST_HALT: leave_halt = clear_i;
         default: ;
      endcase
   end
   assign state_o = state;

   assign b_err   = b_hs ? resp_err(m_bresp) : 2'b00;
   assign r_err   = r_hs ? resp_err(m_rresp) : 2'b00;
   assign rsp_err = b_err | r_err;

   // New errors are OR-ed in after the clear so a same-cycle error survives it.
   always_comb begin
      err_next = clear_i ? 3'b000 : err_o;
      if (any_to)     err_next[ERR_TIMEOUT] = 1'b1;
      if (rsp_err[0]) err_next[ERR_SLVERR]  = 1'b1;
      if (rsp_err[1]) err_next[ERR_DECERR]  = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_o    <= 3'b000;
         err_id_o <= '0;
      end else begin
         err_o <= err_next;
         if ((clear_i || err_o[1:0] == 2'b00) && rsp_err != 2'b00)
            err_id_o <= (b_err != 2'b00) ? m_bid : m_rid;
         else if (clear_i)
            err_id_o <= '0;
      end
   end

endmodule

// File: tb/tb_axi_ddr_guard.sv
// Directed and randomized checks of axi_ddr_guard against a cycle-level
// behavioural model of outstanding counts, stall timers, state and error flags.
module tb_axi_ddr_guard;

   localparam int AW = 32, DW = 32, IW = 4, UW = 1, MAX_OUT = 4, TMO = 1024;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [IW-1:0] s_awid, m_awid, s_arid, m_arid, s_bid, m_bid, s_rid, m_rid, err_id_o;
   logic [AW-1:0] s_awaddr, m_awaddr, s_araddr, m_araddr;
   logic [7:0] s_awlen, m_awlen, s_arlen, m_arlen;
   logic [2:0] s_awsize, m_awsize, s_arsize, m_arsize, s_awprot, m_awprot, s_arprot, m_arprot, err_o;
   logic [1:0] s_awburst, m_awburst, s_arburst, m_arburst, s_bresp, m_bresp, s_rresp, m_rresp, state_o;
   logic s_awlock, m_awlock, s_arlock, m_arlock;
   logic [3:0] s_awcache, m_awcache, s_arcache, m_arcache, s_awqos, m_awqos, s_arqos, m_arqos;
   logic [3:0] s_awregion, m_awregion, s_arregion, m_arregion;
   logic [UW-1:0] s_awuser, m_awuser, s_aruser, m_aruser, s_wuser, m_wuser, s_buser, m_buser, s_ruser, m_ruser;
   logic s_awvalid, s_awready, m_awvalid, m_awready, s_arvalid, s_arready, m_arvalid, m_arready;
   logic [DW-1:0] s_wdata, m_wdata, s_rdata, m_rdata;
   logic [DW/8-1:0] s_wstrb, m_wstrb;
   logic s_wlast, m_wlast, s_wvalid, s_wready, m_wvalid, m_wready;
   logic s_bvalid, s_bready, m_bvalid, m_bready;
   logic s_rlast, m_rlast, s_rvalid, s_rready, m_rvalid, m_rready;
   logic enable_i, clear_i;
   logic [2:0] wr_outstanding_o, rd_outstanding_o;

   int total = 0, bad = 0;
   int m_st, m_wr, m_rd, m_wt, m_rt;
   bit m_awp, m_arp, last_aw_hs, last_ar_hs;
   logic [2:0] m_err;
   logic [IW-1:0] m_eid;

   always #5 clk = ~clk;

   axi_ddr_guard #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW),
                   .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot), .s_awqos(s_awqos),
      .s_awregion(s_awregion), .s_awuser(s_awuser), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wuser(s_wuser),
      .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_buser(s_buser), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot), .s_arqos(s_arqos),
      .s_arregion(s_arregion), .s_aruser(s_aruser), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_ruser(s_ruser),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
      .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos),
      .m_awregion(m_awregion), .m_awuser(m_awuser), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wuser(m_wuser),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_buser(m_buser), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
      .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos),
      .m_arregion(m_arregion), .m_aruser(m_aruser), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_ruser(m_ruser),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .enable_i(enable_i), .clear_i(clear_i), .state_o(state_o),
      .wr_outstanding_o(wr_outstanding_o), .rd_outstanding_o(rd_outstanding_o),
      .err_o(err_o), .err_id_o(err_id_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      m_st = 0; m_wr = 0; m_rd = 0; m_wt = 0; m_rt = 0;
      m_awp = 0; m_arp = 0; m_err = 3'b000; m_eid = '0;
   endtask

   task automatic idle_inputs();
      s_awvalid = 0; s_arvalid = 0; s_wvalid = 0; m_bvalid = 0; m_rvalid = 0;
      m_awready = 1; m_arready = 1; m_wready = 1; s_bready = 1; s_rready = 1;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rlast = 0; clear_i = 0;
   endtask

   // One clock: check the DUT against the model, then advance the model by the
   // spec rules using the handshakes the model itself predicts.
   task automatic tick();
      bit exp_awv, exp_arv, aw_hs, ar_hs, w_hs, b_hs, r_hs, r_end, wto, rto, leave, b_err, r_err;
      logic [2:0] e;
      int ns;
      #1;
      exp_awv = m_awp || (m_st == 1 && m_wr < MAX_OUT && s_awvalid);
      exp_arv = m_arp || (m_st == 1 && m_rd < MAX_OUT && s_arvalid);
      chk("m_awvalid", 32'(m_awvalid), 32'(exp_awv));
      chk("s_awready", 32'(s_awready), 32'(exp_awv && m_awready));
      chk("m_arvalid", 32'(m_arvalid), 32'(exp_arv));
      chk("s_arready", 32'(s_arready), 32'(exp_arv && m_arready));
      chk("state", 32'(state_o), 32'(m_st));
      chk("wr_cnt", 32'(wr_outstanding_o), 32'(m_wr));
      chk("rd_cnt", 32'(rd_outstanding_o), 32'(m_rd));
      chk("err", 32'(err_o), 32'(m_err));
      chk("err_id", 32'(err_id_o), 32'(m_eid));
      chk("awaddr_pass", m_awaddr, s_awaddr);
      chk("arid_pass", 32'(m_arid), 32'(s_arid));
      chk("w_pass", {m_wvalid, m_wdata[30:0]}, {s_wvalid, s_wdata[30:0]});
      chk("b_pass", {27'(s_bid), s_bvalid, m_bready, s_bresp}, {27'(m_bid), m_bvalid, s_bready, m_bresp});
      chk("r_pass", s_rdata ^ {28'(0), s_rvalid, s_rlast, m_rready, s_wready},
          m_rdata ^ {28'(0), m_rvalid, m_rlast, s_rready, m_wready});

      aw_hs = exp_awv && m_awready;
      ar_hs = exp_arv && m_arready;
      w_hs  = s_wvalid && m_wready;
      b_hs  = m_bvalid && s_bready;
      r_hs  = m_rvalid && s_rready;
      r_end = r_hs && m_rlast;
      wto   = m_wr > 0 && m_wt == TMO - 1;
      rto   = m_rd > 0 && m_rt == TMO - 1;
      b_err = b_hs && m_bresp[1];
      r_err = r_hs && m_rresp[1];

      e = clear_i ? 3'b000 : m_err;
      if (wto || rto) e[2] = 1'b1;
      if (b_err) begin if (m_bresp[0]) e[1] = 1'b1; else e[0] = 1'b1; end
      if (r_err) begin if (m_rresp[0]) e[1] = 1'b1; else e[0] = 1'b1; end
      if ((clear_i || m_err[1:0] == 2'b00) && (b_err || r_err)) m_eid = b_err ? m_bid : m_rid;
      else if (clear_i) m_eid = '0;
      m_err = e;

      leave = 0;
      ns = m_st;
      case (m_st)
         0: if (enable_i) ns = 1;
         1: if (wto || rto) ns = 3; else if (!enable_i) ns = 2;
         2: if (wto || rto) ns = 3; else if (enable_i) ns = 1;
            else if (m_wr == 0 && m_rd == 0 && !m_awp && !m_arp) ns = 0;
         default: if (clear_i) begin leave = 1; ns = enable_i ? 1 : 2; end
      endcase
      m_st = ns;

      if (leave || m_wr == 0 || aw_hs || w_hs || b_hs) m_wt = 0; else m_wt++;
      if (leave || m_rd == 0 || ar_hs || r_hs) m_rt = 0; else m_rt++;
      if (aw_hs && !b_hs) m_wr++; else if (b_hs && !aw_hs && m_wr > 0) m_wr--;
      if (ar_hs && !r_end) m_rd++; else if (r_end && !ar_hs && m_rd > 0) m_rd--;
      m_awp = exp_awv && !m_awready;
      m_arp = exp_arv && !m_arready;
      last_aw_hs = aw_hs;
      last_ar_hs = ar_hs;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      s_awid = '0; s_awaddr = '0; s_awlen = 8'd3; s_awsize = 3'd2; s_awburst = 2'b01; s_awlock = 0;
      s_awcache = 4'h3; s_awprot = 3'd0; s_awqos = 4'd0; s_awregion = 4'd0; s_awuser = '0;
      s_arid = '0; s_araddr = '0; s_arlen = 8'd3; s_arsize = 3'd2; s_arburst = 2'b01; s_arlock = 0;
      s_arcache = 4'h3; s_arprot = 3'd0; s_arqos = 4'd0; s_arregion = 4'd0; s_aruser = '0;
      s_wdata = '0; s_wstrb = '1; s_wlast = 1; s_wuser = '0;
      m_bid = '0; m_buser = '0; m_rid = '0; m_rdata = '0; m_ruser = '0;
      enable_i = 0;
      idle_inputs();

      // Reset: outputs quiet even with requests presented.
      rst_n = 0;
      s_awvalid = 1; s_arvalid = 1;
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(state_o), 0);
      chk("rst_cnts", {wr_outstanding_o, rd_outstanding_o}, 0);
      chk("rst_err", {err_o, err_id_o}, 0);
      chk("rst_addr_gate", {m_awvalid, s_awready, m_arvalid, s_arready}, 0);
      s_awvalid = 0; s_arvalid = 0;
      rst_n = 1;
      mdl_reset();
      @(negedge clk);

      // Five back-to-back ARs with no read data: only four get through.
      enable_i = 1;
      tick();
      s_arvalid = 1;
      for (int i = 0; i < 5; i++) begin
         s_arid = 4'(i); s_araddr = $urandom;
         tick();
      end
      chk("ar5_rd_cnt", 32'(rd_outstanding_o), 4);
      chk("ar5_blocked", 32'(s_arready), 0);
      m_rvalid = 1; m_rlast = 1; m_rid = 4'd0;
      tick();
      m_rvalid = 0;
      #1 chk("ar5_accept_after_rlast", 32'(s_arready), 1);
      tick();
      s_arvalid = 0;
      m_rvalid = 1;
      repeat (4) tick();
      m_rvalid = 0; m_rlast = 0;
      chk("ar5_drained", 32'(rd_outstanding_o), 0);

      // AW and B in the same cycle at count 2.
      s_awvalid = 1;
      repeat (2) tick();
      m_bvalid = 1;
      tick();
      s_awvalid = 0; m_bvalid = 0;
      chk("awb_same_cycle", 32'(wr_outstanding_o), 2);
      m_bvalid = 1;
      repeat (2) tick();
      m_bvalid = 0;

      // DECERR on R (id 5) then SLVERR on B (id 9): first id is kept.
      s_arvalid = 1; tick(); s_arvalid = 0;
      s_awvalid = 1; tick(); s_awvalid = 0;
      m_rvalid = 1; m_rlast = 1; m_rresp = 2'b11; m_rid = 4'd5; tick();
      m_rvalid = 0; m_rlast = 0; m_rresp = 2'b00;
      m_bvalid = 1; m_bresp = 2'b10; m_bid = 4'd9; tick();
      m_bvalid = 0; m_bresp = 2'b00;
      chk("err_flags", 32'(err_o), 32'(3'b011));
      chk("err_first_id", 32'(err_id_o), 5);
      clear_i = 1; tick(); clear_i = 0;
      chk("err_cleared", {err_o, err_id_o}, 0);

      // Drop enable with two writes outstanding.
      s_awvalid = 1; repeat (2) tick(); s_awvalid = 0;
      enable_i = 0;
      tick();
      chk("drain_enter", 32'(state_o), 2);
      m_bvalid = 1; repeat (2) tick(); m_bvalid = 0;
      tick();
      chk("drain_to_idle", 32'(state_o), 0);

      // One AW with B stalled for the full timeout.
      enable_i = 1;
      tick();
      s_awvalid = 1; tick(); s_awvalid = 0;
      repeat (TMO - 1) tick();
      chk("tmo_not_yet", 32'(state_o), 1);
      tick();
      chk("tmo_err", 32'(err_o), 32'(3'b100));
      chk("tmo_halt", 32'(state_o), 3);
      s_awvalid = 1;
      #1 chk("tmo_aw_blocked", {31'(0), m_awvalid}, 0);
      tick();
      s_awvalid = 0;
      clear_i = 1; tick(); clear_i = 0;
      chk("tmo_clear_run", 32'(state_o), 1);
      chk("tmo_clear_err", 32'(err_o), 0);
      chk("tmo_count_kept", 32'(wr_outstanding_o), 1);
      m_bvalid = 1; tick(); m_bvalid = 0;

      // Randomized traffic; responses only while the model has something outstanding.
      for (int c = 0; c < 600; c++) begin
         if (!s_awvalid) begin
            s_awvalid = ($urandom_range(0, 2) == 0); s_awid = 4'($urandom); s_awaddr = $urandom;
         end
         if (!s_arvalid) begin
            s_arvalid = ($urandom_range(0, 2) == 0); s_arid = 4'($urandom); s_araddr = $urandom;
         end
         m_awready = ($urandom_range(0, 3) != 0);
         m_arready = ($urandom_range(0, 3) != 0);
         s_wvalid = 1'($urandom); m_wready = 1'($urandom); s_wdata = $urandom;
         m_bvalid = (m_wr > 0) && ($urandom_range(0, 2) == 0);
         m_bid = 4'($urandom); m_bresp = 2'($urandom);
         s_bready = ($urandom_range(0, 3) != 0);
         m_rvalid = (m_rd > 0) && ($urandom_range(0, 2) == 0);
         m_rlast = 1'($urandom); m_rid = 4'($urandom); m_rdata = $urandom;
         m_rresp = (m_bvalid && m_bresp[1]) ? 2'b00 : 2'($urandom);
         s_rready = ($urandom_range(0, 3) != 0);
         clear_i = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 30) == 0) begin
            if (enable_i) enable_i = 0;
            else if (m_st != 2) enable_i = 1;
         end
         tick();
         if (last_aw_hs) s_awvalid = 0;
         if (last_ar_hs) s_arvalid = 0;
      end

      // Reset while an AR is held on the DDR side.
      idle_inputs();
      enable_i = 1;
      for (int k = 0; k < 16 && (m_wr > 0 || m_rd > 0 || m_st != 1); k++) begin
         m_bvalid = (m_wr > 0); m_rvalid = (m_rd > 0); m_rlast = 1;
         tick();
      end
      idle_inputs();
      chk("pre_rst_run", 32'(state_o), 1);
      s_arvalid = 1; tick();
      m_arready = 0; tick();
      chk("pre_rst_arvalid", 32'(m_arvalid), 1);
      rst_n = 0;
      #1;
      chk("rst_arvalid_drop", {31'(0), m_arvalid}, 0);
      chk("rst_mid_cnts", {wr_outstanding_o, rd_outstanding_o}, 0);
      chk("rst_mid_state", 32'(state_o), 0);
      s_arvalid = 0;
      @(negedge clk);
      rst_n = 1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
